fpu_out_arb_q: RTL and testbench

Parametrised FPU result return stage: collects completed results from NPIPE execution pipes into per-pipe FIFOs and arbitrates them round-robin onto the CPX return path. Builds the 145-bit CPX packet and throttles issue with a CPX credit counter. Sits between the add/mul/div pipe output stages and the CPX interface. Unlike the earlier fixed single-cycle output mux, it buffers results and applies back-pressure, so pipes never need a same-cycle grant.

---
 rtl/fpu_out_arb_q.sv | 166 ++++++++++++++++
 tb/tb_fpu_out_arb_q.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_out_arb_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_out_arb_q                                                |
// | Description : FPU result return stage. Completed results from NPIPE        |
// |               execution pipes are buffered in per-pipe FIFOs and issued    |
// |               round-robin onto the CPX return path as 145-bit packets,     |
// |               throttled by a CPX credit counter.                           |
// | Ports       : rclk, rst            clock, synchronous active-high reset    |
// |               pipe_vld/pipe_rdy    per-pipe push handshake                 |
// |               pipe_thr/exc/aux/data  per-pipe result fields (packed)       |
// |               cpx_credit           one-cycle credit return pulse          |
// |               fp_cpx_vld/data_ca   registered CPX packet                   |
// |               credit_ovf           registered credit overflow pulse        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fpu_out_arb_q #(
  parameter int NPIPE   = 3,
  parameter int DEPTH   = 2,
  parameter int CREDITS = 2
) (
  input  logic                 rclk,
  input  logic                 rst,
  input  logic [NPIPE-1:0]     pipe_vld,
  output logic [NPIPE-1:0]     pipe_rdy,
  input  logic [2*NPIPE-1:0]   pipe_thr,
  input  logic [5*NPIPE-1:0]   pipe_exc,
  input  logic [8*NPIPE-1:0]   pipe_aux,
  input  logic [64*NPIPE-1:0]  pipe_data,
  input  logic                 cpx_credit,
  output logic                 fp_cpx_vld,
  output logic [144:0]         fp_cpx_data_ca,
  output logic                 credit_ovf
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              EW       = 79;
  localparam int              RRW      = (NPIPE > 1) ? $clog2(NPIPE) : 1;
  localparam int              NSLOT    = 1 << RRW;
  localparam logic [RRW-1:0]  LAST     = RRW'(NPIPE - 1);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [3:0]      CRED_MAX = 4'(CREDITS);

  // Arrays padded to a power of two so the round-robin index never
  // selects outside the declared range.
  logic [NSLOT-1:0] nonempty;
  logic [EW-1:0]    head [NSLOT];
  logic [NPIPE-1:0] pop;

  logic             grant_vld;
  logic [RRW-1:0]   grant_idx;
  logic [RRW-1:0]   scan_idx;
  logic [RRW-1:0]   rr;
  logic [3:0]       credits;
  logic [EW-1:0]    win_entry;
  logic [144:0]     pkt;

  generate
    for (genvar i = 0; i < NPIPE; i++) begin : g_pipe
      logic [EW-1:0] mem [DEPTH];
      logic [AW-1:0] wptr;
      logic [AW-1:0] rptr;
      logic [AW:0]   cnt;
      logic          push;
      logic [EW-1:0] din;

      // Full is judged on the start-of-cycle count, so a same-cycle pop
      // never opens room for a push.
      assign pipe_rdy[i] = (cnt != FULL_CNT);
      assign push        = pipe_vld[i] & pipe_rdy[i] & ~rst;
      assign din         = {pipe_thr[2*i +: 2], pipe_exc[5*i +: 5],
                            pipe_aux[8*i +: 8], pipe_data[64*i +: 64]};
      assign nonempty[i] = (cnt != '0);
      assign head[i]     = mem[rptr];
      assign pop[i]      = grant_vld && (grant_idx == RRW'(i));

      always_ff @(posedge rclk) begin
        if (push) begin
          mem[wptr] <= din;
        end
      end

      always_ff @(posedge rclk) begin
        if (rst) begin
          wptr <= '0;
          rptr <= '0;
          cnt  <= '0;
        end else begin
          if (push) begin
            wptr <= wptr + 1'b1;
          end
          if (pop[i]) begin
            rptr <= rptr + 1'b1;
          end
          case ({push, pop[i]})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
          endcase
        end
      end
    end

    for (genvar j = NPIPE; j < NSLOT; j++) begin : g_pad
      assign nonempty[j] = 1'b0;
      assign head[j]     = '0;
    end
  endgenerate

  // Round-robin search starting at rr, wrapping at NPIPE; nothing issues
  // without a credit.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr;
    scan_idx  = rr;
    for (int k = 0; k < NPIPE; k++) begin
      if (!grant_vld && nonempty[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
    end
    if (credits == 4'd0) begin
      grant_vld = 1'b0;
    end
  end

  assign win_entry = head[grant_idx];
  assign pkt = {1'b1, 4'b1000, 4'b0000, win_entry[78:77], 57'd0, win_entry[76:0]};

  always_ff @(posedge rclk) begin
    if (rst) begin
      fp_cpx_vld     <= 1'b0;
      fp_cpx_data_ca <= '0;
      rr             <= '0;
    end else begin
      fp_cpx_vld     <= grant_vld;
      fp_cpx_data_ca <= grant_vld ? pkt : '0;
      if (grant_vld) begin
        rr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // A credit returned at the ceiling with no issue is dropped and flagged.
  always_ff @(posedge rclk) begin
    if (rst) begin
      credits    <= CRED_MAX;
      credit_ovf <= 1'b0;
    end else begin
      credit_ovf <= 1'b0;
      case ({grant_vld, cpx_credit})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CRED_MAX) begin
            credit_ovf <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        default: credits <= credits;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_out_arb_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fpu_out_arb_q                                             |
// | Description : Scoreboard bench for fpu_out_arb_q. Stimulus pushes the      |
// |               expected packets into a queue; a negedge monitor pops and    |
// |               compares every packet the DUT presents.                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fpu_out_arb_q;

  localparam int NPIPE   = 3;
  localparam int DEPTH   = 2;
  localparam int CREDITS = 2;

  logic                rclk = 1'b0;
  logic                rst;
  logic [NPIPE-1:0]    pipe_vld;
  logic [NPIPE-1:0]    pipe_rdy;
  logic [2*NPIPE-1:0]  pipe_thr;
  logic [5*NPIPE-1:0]  pipe_exc;
  logic [8*NPIPE-1:0]  pipe_aux;
  logic [64*NPIPE-1:0] pipe_data;
  logic                cpx_credit;
  logic                fp_cpx_vld;
  logic [144:0]        fp_cpx_data_ca;
  logic                credit_ovf;

  int           checks  = 0;
  int           passes  = 0;
  int           pkt_cnt = 0;
  int           base_cnt;
  bit           mon_en  = 1'b0;
  logic [144:0] expq[$];
  logic [NPIPE-1:0] snap;
  int           sent[NPIPE];

  always #5 rclk = ~rclk;

  fpu_out_arb_q #(.NPIPE(NPIPE), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .rclk          (rclk),
    .rst           (rst),
    .pipe_vld      (pipe_vld),
    .pipe_rdy      (pipe_rdy),
    .pipe_thr      (pipe_thr),
    .pipe_exc      (pipe_exc),
    .pipe_aux      (pipe_aux),
    .pipe_data     (pipe_data),
    .cpx_credit    (cpx_credit),
    .fp_cpx_vld    (fp_cpx_vld),
    .fp_cpx_data_ca(fp_cpx_data_ca),
    .credit_ovf    (credit_ovf)
  );

  task automatic chk(input string name, input logic [144:0] act, input logic [144:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Tagged entry {thr, exc, aux, data} for pipe p.
  function automatic logic [78:0] ent(input int p, input logic [7:0] tag);
    logic [7:0] pb;
    pb = 8'(p);
    return {tag[1:0], tag[4:0] ^ pb[4:0], pb[3:0], tag[3:0], pb, tag, 48'h0123_4567_89AB};
  endfunction

  function automatic logic [144:0] pk(input logic [78:0] e);
    return {1'b1, 4'b1000, 4'b0000, e[78:77], 57'd0, e[76:0]};
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input int p, input logic [7:0] tag);
    logic [78:0] e;
    e = ent(p, tag);
    pipe_vld[p]          = 1'b1;
    pipe_thr[2*p +: 2]   = e[78:77];
    pipe_exc[5*p +: 5]   = e[76:72];
    pipe_aux[8*p +: 8]   = e[71:64];
    pipe_data[64*p +: 64] = e[63:0];
  endtask

  task automatic do_reset();
    chk("drained_before_reset", 145'(expq.size()), 145'd0);
    expq.delete();
    rst        = 1'b1;
    pipe_vld   = '0;
    cpx_credit = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_vld", 145'(fp_cpx_vld), 145'd0);
    chk("rst_data", fp_cpx_data_ca, 145'd0);
    chk("rst_ovf", 145'(credit_ovf), 145'd0);
    chk("rst_rdy", 145'(pipe_rdy), 145'(3'b111));
  endtask

  // Monitor: every presented packet must match the queue head; idle
  // cycles must carry an all-zero packet.
  always @(negedge rclk) begin
    logic [144:0] e;
    if (mon_en) begin
      if (fp_cpx_vld) begin
        pkt_cnt++;
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pkt: got %h expected no packet", fp_cpx_data_ca);
        end else begin
          e = expq.pop_front();
          chk("pkt", fp_cpx_data_ca, e);
        end
      end else begin
        chk("idle_zero", fp_cpx_data_ca, 145'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pipe_vld = '0; pipe_thr = '0; pipe_exc = '0;
    pipe_aux = '0; pipe_data = '0; cpx_credit = 1'b0;
    repeat (2) step();
    do_reset();
    mon_en = 1'b1;

    // Single add push: two-edge latency, exact packet fields.
    pipe_vld[0] = 1'b1; pipe_thr[1:0] = 2'd2; pipe_exc[4:0] = 5'h01;
    pipe_aux[7:0] = 8'h00; pipe_data[63:0] = 64'h3FF0_0000_0000_0000;
    expq.push_back({1'b1, 4'b1000, 4'b0, 2'd2, 57'd0, 5'h01, 8'h00, 64'h3FF0_0000_0000_0000});
    step();
    pipe_vld[0] = 1'b0;
    chk("lat_not_yet", 145'(fp_cpx_vld), 145'd0);
    step();
    chk("lat_vld", 145'(fp_cpx_vld), 145'd1);
    chk("hdr", 145'(fp_cpx_data_ca[144:140]), 145'(5'b11000));
    chk("thr", 145'(fp_cpx_data_ca[135:134]), 145'd2);
    chk("exc", 145'(fp_cpx_data_ca[76:72]), 145'd1);
    chk("data", 145'(fp_cpx_data_ca[63:0]), 145'(64'h3FF0_0000_0000_0000));
    step();
    chk("after_vld", 145'(fp_cpx_vld), 145'd0);
    chk("after_data", fp_cpx_data_ca, 145'd0);

    // Credit return to the ceiling, then overflow pulse.
    cpx_credit = 1'b1;
    step();
    chk("ovf_none", 145'(credit_ovf), 145'd0);
    step();
    chk("ovf_pulse", 145'(credit_ovf), 145'd1);
    cpx_credit = 1'b0;
    step();
    chk("ovf_clear", 145'(credit_ovf), 145'd0);

    // Round robin with all pipes pushing and credits returned per issue.
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int p = 0; p < NPIPE; p++) expq.push_back(pk(ent(p, 8'(8'h20 + j))));
    for (int p = 0; p < NPIPE; p++) sent[p] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < NPIPE; p++)
        if (sent[p] < 2) drive(p, 8'(8'h20 + sent[p])); else pipe_vld[p] = 1'b0;
      cpx_credit = (c >= 1 && c <= 6);
      snap = pipe_rdy;
      step();
      for (int p = 0; p < NPIPE; p++) if (pipe_vld[p] && snap[p]) sent[p]++;
      if (c >= 1 && c <= 6) chk("rr_nogap", 145'(fp_cpx_vld), 145'd1);
      else if (c == 7) chk("rr_end_idle", 145'(fp_cpx_vld), 145'd0);
    end
    pipe_vld = '0; cpx_credit = 1'b0;
    // Issue+credit pairs must leave the counter at the ceiling.
    cpx_credit = 1'b1;
    step();
    cpx_credit = 1'b0;
    chk("cnt_unchanged_ovf", 145'(credit_ovf), 145'd1);
    step();

    // Credit starvation: 4 pushes to pipe 1, only 2 issue.
    do_reset();
    base_cnt = pkt_cnt;
    sent[1] = 0;
    expq.push_back(pk(ent(1, 8'h30)));
    expq.push_back(pk(ent(1, 8'h31)));
    for (int c = 0; c < 8; c++) begin
      if (sent[1] < 4) drive(1, 8'(8'h30 + sent[1])); else pipe_vld[1] = 1'b0;
      snap = pipe_rdy;
      step();
      if (pipe_vld[1] && snap[1]) sent[1]++;
    end
    pipe_vld = '0;
    chk("stall_pkts", 145'(pkt_cnt - base_cnt), 145'd2);
    chk("stall_rdy1", 145'(pipe_rdy[1]), 145'd0);
    chk("stall_vld", 145'(fp_cpx_vld), 145'd0);
    expq.push_back(pk(ent(1, 8'h32)));
    cpx_credit = 1'b1;
    step();
    cpx_credit = 1'b0;
    step();
    chk("release_vld", 145'(fp_cpx_vld), 145'd1);
    chk("release_rdy1", 145'(pipe_rdy[1]), 145'd1);
    step();
    chk("release_one", 145'(fp_cpx_vld), 145'd0);
    chk("release_pkts", 145'(pkt_cnt - base_cnt), 145'd3);

    // Full FIFO popped while pushing: refused, then order across wrap.
    do_reset();
    base_cnt = pkt_cnt;
    expq.push_back(pk(ent(2, 8'h40)));
    expq.push_back(pk(ent(2, 8'h41)));
    for (int k = 0; k < 5; k++) expq.push_back(pk(ent(0, 8'(8'h50 + k))));
    drive(2, 8'h40); step();
    drive(2, 8'h41); step();
    pipe_vld[2] = 1'b0;
    sent[0] = 0;
    for (int c = 0; c < 15; c++) begin
      if (sent[0] < 5) drive(0, 8'(8'h50 + sent[0])); else pipe_vld[0] = 1'b0;
      cpx_credit = (c == 4) || (c >= 7 && c <= 11);
      snap = pipe_rdy;
      step();
      if (pipe_vld[0] && snap[0]) sent[0]++;
      if (c == 5) chk("full_pop_refuse", 145'(snap[0]), 145'd0);
      if (c == 6) chk("refused_then_accept", 145'(snap[0]), 145'd1);
    end
    pipe_vld = '0; cpx_credit = 1'b0;
    step();
    chk("wrap_pkts", 145'(pkt_cnt - base_cnt), 145'd7);

    // Reset with three entries buffered and no credits left.
    do_reset();
    expq.push_back(pk(ent(2, 8'h60)));
    expq.push_back(pk(ent(2, 8'h61)));
    drive(2, 8'h60); step();
    drive(2, 8'h61); step();
    pipe_vld[2] = 1'b0;
    drive(0, 8'h70); drive(1, 8'h80);
    step();
    drive(0, 8'h71); pipe_vld[1] = 1'b0;
    step();
    pipe_vld = '0;
    step();
    chk("buffered_rdy0", 145'(pipe_rdy[0]), 145'd0);
    do_reset();
    cpx_credit = 1'b1;
    repeat (3) step();
    cpx_credit = 1'b0;
    repeat (3) step();
    chk("no_stale_vld", 145'(fp_cpx_vld), 145'd0);

    chk("total_pkts", 145'(pkt_cnt), 145'd19);
    chk("queue_empty", 145'(expq.size()), 145'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
